wbu_lq: RTL and testbench
=========================

# wbu_lq

Parametrised in-order writeback stage with a load-pending queue. It sits between the load/store stage and the register file. It accepts retiring instructions over a valid/ready handshake and holds loads until their memory response returns. It extracts and extends sub-word load data, then drives one registered register-file write per cycle in program order.

## Interface
- `DataWidth`, 32: data path width; must be 32 or 64.
- `RegAddrWidth`, 5: destination register address width.
- `Depth`, 4: queue entries (power of two, ≥2).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: stage can accept.
- `in_regwrite` input 1: instruction writes a register.
- `in_memtoreg` input 1: instruction is a load (result comes from `mem_rdata`).
- `in_addr_dst` input RegAddrWidth: destination register.
- `in_alu_result` input DataWidth: non-load result.
- `in_ld_size` input 2: 00 byte, 01 half, 10 word, 11 double (64-bit only).
- `in_ld_unsigned` input 1: zero-extend when 1, sign-extend when 0.
- `in_ld_offset` input $clog2(DataWidth/8): byte offset of the load within the data word.
- `mem_rvalid` input 1: load response valid; no backpressure.
- `mem_rdata` input DataWidth: load response data.
- `wbu_we` output 1: register-file write enable (registered).
- `wbu_addr_dst` output RegAddrWidth: write address (registered).
- `wbu_result` output DataWidth: write data (registered).
- `wbu_err` output 1: sticky protocol error.

## Operation
- **Queue.** In-order FIFO of `Depth` entries. Each entry holds regwrite, memtoreg, addr_dst, alu_result, ld_size, ld_unsigned and ld_offset.
- **Acceptance.** An instruction is accepted when `in_valid && in_ready`.
- **Head retire condition.** The head retires when it is a non-load, or when it is a load and `mem_rvalid` is high. At most one retire per cycle.
- **Bypass.** When the queue is empty, an accepted instruction that meets the retire condition in the same cycle goes straight to the output registers and is not enqueued. Otherwise it is enqueued.
- **Responses.** `mem_rvalid` is consumed only by a load at the head, or by a bypassing load.
  - `mem_rvalid` while the head is a non-load, or while the queue is empty with no load being accepted, sets `wbu_err`. The response is discarded.
- **Write outputs on retire.**
  - `wbu_we` = regwrite && (addr_dst != 0).
  - `wbu_addr_dst` = addr_dst.
  - `wbu_result` = extracted load data if memtoreg, otherwise alu_result.
- **No retire.** `wbu_we` = 0. `wbu_addr_dst` and `wbu_result` hold their last values.
- **Entries with regwrite = 0** (stores, branches) still occupy a slot and retire in order, with `wbu_we` = 0.
- **Load extraction.**
  - Byte: `mem_rdata[8*off +: 8]`.
  - Half: `mem_rdata[16*off[msb:1] +: 16]`, where the low offset bit is ignored.
  - Word: `mem_rdata[32*off[msb:2] +: 32]`.
  - Double: full word.
  - Result is extended to DataWidth per `ld_unsigned`.

## Timing
- **Reset values.**
  - `wbu_we` = 0, `wbu_addr_dst` = 0, `wbu_result` = 0, `wbu_err` = 0.
  - Queue empty; `in_ready` = 1 after reset.
  - Reset asserted mid-operation drops all pending entries immediately. No write occurs for them.
- **Latency.**
  - Non-load into an empty queue: `wbu_we` high the cycle after acceptance.
  - Load: `wbu_we` high the cycle after the `mem_rvalid` that serves it.
  - Queued non-load behind a load: retires the cycle after the load retires.
- **Ready.**
  - `in_ready` = (count < Depth), registered from count.
  - When full, a same-cycle retire does not allow acceptance in that cycle.
- **Simultaneous accept and retire.** Accept and retire in the same cycle leave count unchanged. Read and write pointers wrap modulo `Depth`.
- **Throughput.** Sustained one instruction per cycle while no load is waiting.

## Configuration
- `WBU_LOAD_ALIGN_EN`:
  - **Defined:** load extraction and extension as described above.
  - **Undefined:** `wbu_result` = `mem_rdata` unchanged for loads. `in_ld_size`, `in_ld_unsigned` and `in_ld_offset` are ignored and not stored in the queue.

## Test plan
- **ALU bypass.** Reset, then accept a non-load with addr 5 and alu_result 0x0000_1234 into an empty queue → next cycle `wbu_we`=1, `wbu_addr_dst`=5, `wbu_result`=0x0000_1234.
- **Load ordering.** Accept load (addr 3, byte, signed, off 2), then ALU (addr 4, 0x11) → no write until `mem_rvalid` with `mem_rdata`=0x0080_0000.
  - Then cycle 1: addr 3 with 0xFFFF_FF80.
  - Then cycle 2: addr 4 with 0x11.
- **Full queue.** Accept 4 loads with no responses → `in_ready`=0. One `mem_rvalid` → `in_ready`=1 the next cycle. 4 responses drain the writes in order.
- **x0 and non-writing entries.**
  - regwrite with addr 0 → `wbu_we`=0.
  - Store (regwrite 0) between two ALU ops → write, no write, write.
- **Error.** `mem_rvalid` with the queue empty and no load accepted → `wbu_err`=1 from the next cycle and stays high. No write occurs.
- **Reset mid-operation.** Assert `rst_n`=0 with 3 loads pending, then send responses after release → `wbu_err`=1, no writes, `in_ready`=1.

Source files
------------

// File: rtl/wbu_lq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wbu_lq : in-order writeback stage with load-pending queue.                 |
// | Optional macro WBU_LOAD_ALIGN_EN enables sub-word load extraction.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wbu_lq #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5,
  parameter int Depth        = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_regwrite,
  input  logic                             in_memtoreg,
  input  logic [RegAddrWidth-1:0]          in_addr_dst,
  input  logic [DataWidth-1:0]             in_alu_result,
  input  logic [1:0]                       in_ld_size,
  input  logic                             in_ld_unsigned,
  input  logic [$clog2(DataWidth/8)-1:0]   in_ld_offset,
  input  logic                             mem_rvalid,
  input  logic [DataWidth-1:0]             mem_rdata,
  output logic                             wbu_we,
  output logic [RegAddrWidth-1:0]          wbu_addr_dst,
  output logic [DataWidth-1:0]             wbu_result,
  output logic                             wbu_err
);

  localparam int c_off_w = $clog2(DataWidth/8);
  localparam int c_ptr_w = $clog2(Depth);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic                    r_q_regwrite [Depth];
  logic                    r_q_memtoreg [Depth];
  logic [RegAddrWidth-1:0] r_q_addr     [Depth];
  logic [DataWidth-1:0]    r_q_alu      [Depth];

  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_in_ready;
  logic               r_we;
  logic [RegAddrWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_result;
  logic               r_err;

  logic               w_empty;
  logic               w_accept;
  logic               w_head_retire;
  logic               w_bypass;
  logic               w_enq;
  logic               w_retire;
  logic               w_resp_err;
  logic [c_cnt_w-1:0] w_next_count;
  logic                    w_sel_regwrite;
  logic                    w_sel_memtoreg;
  logic [RegAddrWidth-1:0] w_sel_addr;
  logic [DataWidth-1:0]    w_sel_alu;
  logic [DataWidth-1:0]    w_load_data;
  logic [DataWidth-1:0]    w_sel_result;

`ifdef WBU_LOAD_ALIGN_EN
  logic [1:0]         r_q_size [Depth];
  logic               r_q_uns  [Depth];
  logic [c_off_w-1:0] r_q_off  [Depth];
  logic [1:0]         w_sel_size;
  logic               w_sel_uns;
  logic [c_off_w-1:0] w_sel_off;

  // Shift the addressed lane down to bit 0, then extend from the access width.
  function automatic logic [DataWidth-1:0] f_extract(
    input logic [DataWidth-1:0] data,
    input logic [1:0]           size,
    input logic                 uns,
    input logic [c_off_w-1:0]   off
  );
    logic [c_off_w-1:0]   aoff;
    logic [DataWidth-1:0] sh;
    logic [DataWidth-1:0] res;
    case (size)
      2'b00:   aoff = off;
      2'b01:   aoff = off & ~c_off_w'(1);
      2'b10:   aoff = off & ~c_off_w'(3);
      default: aoff = '0;
    endcase
    sh = data >> {aoff, 3'b000};
    case (size)
      2'b00: begin
        if (uns) res = DataWidth'(sh[7:0]);
        else     res = DataWidth'($signed(sh[7:0]));
      end
      2'b01: begin
        if (uns) res = DataWidth'(sh[15:0]);
        else     res = DataWidth'($signed(sh[15:0]));
      end
      2'b10: begin
        if (uns) res = DataWidth'(sh[31:0]);
        else     res = DataWidth'($signed(sh[31:0]));
      end
      default: res = data;
    endcase
    return res;
  endfunction
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{in_ld_size, in_ld_unsigned, in_ld_offset};
`endif

  assign w_empty       = (r_count == '0);
  assign w_accept      = in_valid && r_in_ready;
  assign w_head_retire = !w_empty && (!r_q_memtoreg[r_rd_ptr] || mem_rvalid);
  assign w_bypass      = w_empty && w_accept && (!in_memtoreg || mem_rvalid);
  assign w_enq         = w_accept && !w_bypass;
  assign w_retire      = w_head_retire || w_bypass;
  // A response is orphaned unless a load at the head or a bypassing load takes it.
  assign w_resp_err    = mem_rvalid &&
                         (w_empty ? !(w_accept && in_memtoreg) : !r_q_memtoreg[r_rd_ptr]);
  assign w_next_count  = r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_head_retire);

  always_comb begin
    if (w_bypass) begin
      w_sel_regwrite = in_regwrite;
      w_sel_memtoreg = in_memtoreg;
      w_sel_addr     = in_addr_dst;
      w_sel_alu      = in_alu_result;
    end else begin
      w_sel_regwrite = r_q_regwrite[r_rd_ptr];
      w_sel_memtoreg = r_q_memtoreg[r_rd_ptr];
      w_sel_addr     = r_q_addr[r_rd_ptr];
      w_sel_alu      = r_q_alu[r_rd_ptr];
    end
  end

`ifdef WBU_LOAD_ALIGN_EN
  always_comb begin
    if (w_bypass) begin
      w_sel_size = in_ld_size;
      w_sel_uns  = in_ld_unsigned;
      w_sel_off  = in_ld_offset;
    end else begin
      w_sel_size = r_q_size[r_rd_ptr];
      w_sel_uns  = r_q_uns[r_rd_ptr];
      w_sel_off  = r_q_off[r_rd_ptr];
    end
  end
  assign w_load_data = f_extract(mem_rdata, w_sel_size, w_sel_uns, w_sel_off);
`else
  assign w_load_data = mem_rdata;
`endif

  assign w_sel_result = w_sel_memtoreg ? w_load_data : w_sel_alu;

  // Queue storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_regwrite[r_wr_ptr] <= in_regwrite;
      r_q_memtoreg[r_wr_ptr] <= in_memtoreg;
      r_q_addr[r_wr_ptr]     <= in_addr_dst;
      r_q_alu[r_wr_ptr]      <= in_alu_result;
`ifdef WBU_LOAD_ALIGN_EN
      r_q_size[r_wr_ptr]     <= in_ld_size;
      r_q_uns[r_wr_ptr]      <= in_ld_unsigned;
      r_q_off[r_wr_ptr]      <= in_ld_offset;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_enq)         r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_head_retire) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count    <= w_next_count;
      r_in_ready <= (w_next_count < c_cnt_w'(Depth));
      if (w_retire) begin
        r_we     <= w_sel_regwrite && (w_sel_addr != '0);
        r_addr   <= w_sel_addr;
        r_result <= w_sel_result;
      end else begin
        r_we     <= 1'b0;
      end
      if (w_resp_err) r_err <= 1'b1;
    end
  end

  assign in_ready     = r_in_ready;
  assign wbu_we       = r_we;
  assign wbu_addr_dst = r_addr;
  assign wbu_result   = r_result;
  assign wbu_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wbu_lq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wbu_lq : self-checking bench for wbu_lq with a queue-based model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wbu_lq;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [4:0]  in_addr_dst;
  logic [31:0] in_alu_result;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [1:0]  in_ld_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wbu_we;
  logic [4:0]  wbu_addr_dst;
  logic [31:0] wbu_result;
  logic        wbu_err;

  wbu_lq #(.DataWidth(32), .RegAddrWidth(5), .Depth(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_addr_dst(in_addr_dst), .in_alu_result(in_alu_result),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_ld_offset(in_ld_offset),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wbu_we(wbu_we), .wbu_addr_dst(wbu_addr_dst), .wbu_result(wbu_result), .wbu_err(wbu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        rw;
    logic        mem;
    logic [4:0]  a;
    logic [31:0] alu;
    logic [1:0]  sz;
    logic        u;
    logic [1:0]  off;
  } ent_t;

  ent_t        q[$];
  ent_t        m_e;
  ent_t        m_in;
  logic        m_acc;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_res;
  logic        m_err;
  logic        m_ready;

`ifdef WBU_LOAD_ALIGN_EN
  function automatic logic [31:0] m_ext(input ent_t e, input logic [31:0] d);
    int nb;
    int base;
    logic [63:0] v;
    logic [63:0] mask;
    nb   = (e.sz == 2'd0) ? 1 : (e.sz == 2'd1) ? 2 : 4;
    base = (int'(e.off) / nb) * nb;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = ({32'd0, d} >> (8 * base)) & mask;
    if (!e.u && v[8 * nb - 1]) v = v | ~mask;
    return v[31:0];
  endfunction
`endif

  function automatic logic [31:0] m_value(input ent_t e, input logic [31:0] d);
    if (!e.mem) return e.alu;
`ifdef WBU_LOAD_ALIGN_EN
    return m_ext(e, d);
`else
    return d;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_we = 0; m_addr = 0; m_res = 0; m_err = 0; m_ready = 1;
    end else begin
      m_in  = '{in_regwrite, in_memtoreg, in_addr_dst, in_alu_result,
                in_ld_size, in_ld_unsigned, in_ld_offset};
      m_acc = in_valid && m_ready;
      m_we  = 0;
      if (q.size() > 0) begin
        m_e = q[0];
        if (!m_e.mem || mem_rvalid) begin
          void'(q.pop_front());
          m_we = m_e.rw && (m_e.a != 0); m_addr = m_e.a; m_res = m_value(m_e, mem_rdata);
        end
        if (mem_rvalid && !m_e.mem) m_err = 1;
        if (m_acc) q.push_back(m_in);
      end else begin
        if (m_acc && (!m_in.mem || mem_rvalid)) begin
          m_we = m_in.rw && (m_in.a != 0); m_addr = m_in.a; m_res = m_value(m_in, mem_rdata);
        end else if (m_acc) begin
          q.push_back(m_in);
        end
        if (mem_rvalid && !(m_acc && m_in.mem)) m_err = 1;
      end
      m_ready = (q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("we",     {31'd0, wbu_we},   {31'd0, m_we});
      check("addr",   {27'd0, wbu_addr_dst}, {27'd0, m_addr});
      check("result", wbu_result,        m_res);
      check("err",    {31'd0, wbu_err},  {31'd0, m_err});
      check("ready",  {31'd0, in_ready}, {31'd0, m_ready});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic rw, input logic mem, input logic [4:0] a,
                      input logic [31:0] alu, input logic [1:0] sz, input logic u,
                      input logic [1:0] off, input logic rv, input logic [31:0] rd);
    in_valid = v; in_regwrite = rw; in_memtoreg = mem; in_addr_dst = a;
    in_alu_result = alu; in_ld_size = sz; in_ld_unsigned = u; in_ld_offset = off;
    mem_rvalid = rv; mem_rdata = rd;
    @(posedge clk); #1;
    in_valid = 0; mem_rvalid = 0;
  endtask

  task automatic alu_op(input logic rw, input logic [4:0] a, input logic [31:0] val);
    step(1, rw, 0, a, val, 2'd0, 0, 2'd0, 0, 32'd0);
  endtask
  task automatic ld_op(input logic [4:0] a, input logic [1:0] sz, input logic u, input logic [1:0] off);
    step(1, 1, 1, a, 32'd0, sz, u, off, 0, 32'd0);
  endtask
  task automatic resp(input logic [31:0] rd);
    step(0, 0, 0, 5'd0, 32'd0, 2'd0, 0, 2'd0, 1, rd);
  endtask
  task automatic idle();
    step(0, 0, 0, 5'd0, 32'd0, 2'd0, 0, 2'd0, 0, 32'd0);
  endtask

`ifdef WBU_LOAD_ALIGN_EN
  localparam logic [31:0] EXP_LB  = 32'hFFFF_FF80;
  localparam logic [31:0] EXP_LHU = 32'h0000_8765;
  localparam logic [31:0] EXP_LH  = 32'hFFFF_8765;
`else
  localparam logic [31:0] EXP_LB  = 32'h0080_0000;
  localparam logic [31:0] EXP_LHU = 32'h8765_4321;
  localparam logic [31:0] EXP_LH  = 32'h8765_4321;
`endif

  initial begin
    in_valid = 0; in_regwrite = 0; in_memtoreg = 0; in_addr_dst = 0; in_alu_result = 0;
    in_ld_size = 0; in_ld_unsigned = 0; in_ld_offset = 0; mem_rvalid = 0; mem_rdata = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", {31'd0, wbu_we}, 32'd0);
    check("rst_addr", {27'd0, wbu_addr_dst}, 32'd0);
    check("rst_result", wbu_result, 32'd0);
    check("rst_err", {31'd0, wbu_err}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1;
    idle();

    // ALU bypass
    alu_op(1, 5'd5, 32'h0000_1234);
    check("byp_we", {31'd0, wbu_we}, 32'd1);
    check("byp_addr", {27'd0, wbu_addr_dst}, 32'd5);
    check("byp_result", wbu_result, 32'h0000_1234);
    idle();
    check("byp_idle_we", {31'd0, wbu_we}, 32'd0);

    // Load ordering
    ld_op(5'd3, 2'd0, 0, 2'd2);
    alu_op(1, 5'd4, 32'h11);
    idle();
    check("lo_wait_we", {31'd0, wbu_we}, 32'd0);
    resp(32'h0080_0000);
    check("lo_ld_addr", {27'd0, wbu_addr_dst}, 32'd3);
    check("lo_ld_result", wbu_result, EXP_LB);
    idle();
    check("lo_alu_addr", {27'd0, wbu_addr_dst}, 32'd4);
    check("lo_alu_result", wbu_result, 32'h11);
    idle();

    // Full queue
    for (int i = 0; i < DEPTH; i++) ld_op(5'(6 + i), 2'd2, 1, 2'd0);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    alu_op(1, 5'd20, 32'hDEAD);
    check("full_ready2", {31'd0, in_ready}, 32'd0);
    resp(32'hA000_0006);
    check("drain_ready", {31'd0, in_ready}, 32'd1);
    check("drain0_addr", {27'd0, wbu_addr_dst}, 32'd6);
    for (int i = 1; i < DEPTH; i++) resp(32'hA000_0000 + 32'(6 + i));
    check("drain3_addr", {27'd0, wbu_addr_dst}, 32'd9);
    check("drain3_result", wbu_result, 32'hA000_0009);
    idle();

    // x0 and non-writing entries
    alu_op(1, 5'd0, 32'h55);
    check("x0_we", {31'd0, wbu_we}, 32'd0);
    alu_op(1, 5'd10, 32'hA);
    check("st_a_we", {31'd0, wbu_we}, 32'd1);
    alu_op(0, 5'd11, 32'hB);
    check("st_b_we", {31'd0, wbu_we}, 32'd0);
    alu_op(1, 5'd12, 32'hC);
    check("st_c_we", {31'd0, wbu_we}, 32'd1);

    // Sub-word loads bypassing with same-cycle responses
    step(1, 1, 1, 5'd13, 32'd0, 2'd1, 1, 2'd2, 1, 32'h8765_4321);
    check("lhu_result", wbu_result, EXP_LHU);
    step(1, 1, 1, 5'd14, 32'd0, 2'd1, 0, 2'd3, 1, 32'h8765_4321);
    check("lh_result", wbu_result, EXP_LH);
    step(1, 1, 1, 5'd15, 32'd0, 2'd0, 1, 2'd1, 1, 32'h8765_4321);
    step(1, 1, 1, 5'd16, 32'd0, 2'd0, 0, 2'd3, 1, 32'h8765_4321);
    step(1, 1, 1, 5'd17, 32'd0, 2'd2, 0, 2'd3, 1, 32'h8765_4321);

    // Back-to-back throughput
    for (int i = 0; i < 6; i++) alu_op(1, 5'(21 + i), 32'(100 + i));
    idle();

    // Orphan response error
    resp(32'h1);
    check("err_set", {31'd0, wbu_err}, 32'd1);
    check("err_no_we", {31'd0, wbu_we}, 32'd0);
    idle();
    check("err_sticky", {31'd0, wbu_err}, 32'd1);

    // Reset with loads pending
    for (int i = 0; i < 3; i++) ld_op(5'(1 + i), 2'd2, 0, 2'd0);
    rst_n = 0;
    #1;
    check("mid_rst_err", {31'd0, wbu_err}, 32'd0);
    check("mid_rst_we", {31'd0, wbu_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    resp(32'hBEEF);
    check("post_rst_err", {31'd0, wbu_err}, 32'd1);
    check("post_rst_we", {31'd0, wbu_we}, 32'd0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    resp(32'hBEEF);
    resp(32'hBEEF);
    check("post_rst_we2", {31'd0, wbu_we}, 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
